fm_demodulator: RTL and testbench

Receive-side counterpart of the FM transmitter chain. The block slices the offset-binary DAC-style RF sample stream produced by the transmitter, or a digitised antenna signal in the same format, into a binary carrier. It counts carrier rising crossings over a fixed gate window of 2^G clocks and converts the count's deviation from the nominal carrier into a signed audio sample. One sample is produced per window. It sits on the same sampling clock and reuses the transmitter's carrier phase increment (`acc_inc`) as its frequency reference.

---
 rtl/fm_demodulator_if.sv | 24 ++
 rtl/fm_demodulator.sv | 107 ++++++++++
 tb/tb_fm_demodulator.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/fm_demodulator_if.sv
// Stream-side signals of the FM demodulator: RF input, carrier reference,
// gain control and the demodulated audio strobe.
interface fm_demodulator_if #(
  parameter int unsigned A = 8,
  parameter int unsigned N = 18,
  parameter int unsigned D = 5
);
  logic                ena;
  logic [D-1:0]        rf;
  logic [N-1:0]        acc_inc;
  logic [3:0]          gain_sh;
  logic signed [A-1:0] audio;
  logic                audio_valid;

  modport master (
    output ena, rf, acc_inc, gain_sh,
    input  audio, audio_valid
  );

  modport slave (
    input  ena, rf, acc_inc, gain_sh,
    output audio, audio_valid
  );
endinterface

// File: rtl/fm_demodulator.sv
// FM demodulator: slices the offset-binary RF stream with hysteresis, counts
// carrier rising crossings over a 2^G-clock gate window and turns the count's
// deviation from the nominal carrier increment into a clamped signed sample.
module fm_demodulator #(
  parameter int unsigned A    = 8,
  parameter int unsigned N    = 18,
  parameter int unsigned D    = 5,
  parameter int unsigned G    = 14,
  parameter int unsigned HYST = 1
) (
  input logic             clk,
  input logic             rst_n,
  fm_demodulator_if.slave bus
);

  localparam int unsigned Mid = 2 ** (D - 1);
  // Thresholds are one bit wider than rf so MID+HYST cannot wrap.
  localparam logic [D:0] HiThr = (D + 1)'(Mid + HYST);
  localparam logic [D:0] LoThr = (D + 1)'(Mid - HYST);
  localparam logic signed [N+1:0] YMax = (N + 2)'((2 ** (A - 1)) - 1);
  localparam logic signed [N+1:0] YMin = ~YMax;

  logic [D-1:0]        rf_q, rf_d;
  logic                s_q, s_d;
  logic                s_prev_q, s_prev_d;
  logic [G-1:0]        wcnt_q, wcnt_d;
  logic [G-1:0]        ccnt_q, ccnt_d;
  logic signed [A-1:0] audio_q, audio_d;
  logic                valid_q, valid_d;

  logic                rise;
  logic                term;
  logic [G:0]          tot;
  logic signed [N+1:0] diff;
  logic signed [N+1:0] y;
  logic signed [A-1:0] y_sat;

  // Crossing detection, window bookkeeping and sample conversion.
  always_comb begin
    rise = s_q & ~s_prev_q;
    term = bus.ena & (wcnt_q == {G{1'b1}});
    // An edge in the terminal cycle still belongs to the closing window.
    tot  = {1'b0, ccnt_q} + (G + 1)'(rise);
    diff = $signed({1'b0, tot, {(N - G){1'b0}}}) - $signed({2'b00, bus.acc_inc});
    y    = diff >>> bus.gain_sh;
    if (y > YMax) begin
      y_sat = YMax[A-1:0];
    end else if (y < YMin) begin
      y_sat = YMin[A-1:0];
    end else begin
      y_sat = y[A-1:0];
    end

    rf_d     = bus.rf;
    s_d      = s_q;
    if ({1'b0, rf_q} > HiThr) begin
      s_d = 1'b1;
    end else if ({1'b0, rf_q} < LoThr) begin
      s_d = 1'b0;
    end
    s_prev_d = s_q;

    wcnt_d  = '0;
    ccnt_d  = '0;
    audio_d = audio_q;
    valid_d = 1'b0;
    if (bus.ena) begin
      wcnt_d = wcnt_q + 1'b1;
      if (term) begin
        audio_d = y_sat;
        valid_d = 1'b1;
      end else if (rise && (ccnt_q != {G{1'b1}})) begin
        ccnt_d = ccnt_q + 1'b1;
      end else begin
        ccnt_d = ccnt_q;
      end
    end
  end

  // State registers; reset discards any partial window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_q     <= '0;
      s_q      <= 1'b0;
      s_prev_q <= 1'b0;
      wcnt_q   <= '0;
      ccnt_q   <= '0;
      audio_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      rf_q     <= rf_d;
      s_q      <= s_d;
      s_prev_q <= s_prev_d;
      wcnt_q   <= wcnt_d;
      ccnt_q   <= ccnt_d;
      audio_q  <= audio_d;
      valid_q  <= valid_d;
    end
  end

  // Registered outputs.
  always_comb begin
    bus.audio       = audio_q;
    bus.audio_valid = valid_q;
  end

endmodule

// File: tb/tb_fm_demodulator.sv
// Scoreboard bench for fm_demodulator. The reference model views the RF input
// as a stream of hysteresis-sliced levels and counts rising transitions that
// fall inside each gate window (shifted by the two-clock slicer latency).
// A short gate window keeps the run length manageable.
module tb_fm_demodulator;

  localparam int unsigned A    = 8;
  localparam int unsigned N    = 18;
  localparam int unsigned D    = 5;
  localparam int unsigned G    = 10;
  localparam int unsigned HYST = 1;
  localparam int          W    = 1 << G;
  localparam int          MID  = 1 << (D - 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fm_demodulator_if #(.A(A), .N(N), .D(D)) bus ();

  fm_demodulator #(.A(A), .N(N), .D(D), .G(G), .HYST(HYST)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];
  int last_audio = 0;
  int lvl_q[$];      // sliced level after each sample since reset; [0] is the reset level
  int run_len = 0;   // consecutive enabled clock edges

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int ref_audio(input int cnt, input int inc, input int gsh);
    longint d;
    d = longint'(cnt) * longint'(1 << (N - G)) - longint'(inc);
    d = d >>> gsh;
    if (d > (1 << (A - 1)) - 1) d = (1 << (A - 1)) - 1;
    if (d < -(1 << (A - 1))) d = -(1 << (A - 1));
    return int'(d);
  endfunction

  task automatic model_reset();
    lvl_q.delete();
    lvl_q.push_back(0);
    run_len = 0;
    exp_q.delete();
    last_audio = 0;
  endtask

  // Called once per clock edge with the inputs that edge will sample.
  task automatic model_edge(input int rfv, input bit en, input int inc, input int gsh);
    int j, lv, cnt, lo;
    j  = lvl_q.size();
    lv = lvl_q[j-1];
    if (rfv > MID + int'(HYST)) lv = 1;
    else if (rfv < MID - int'(HYST)) lv = 0;
    lvl_q.push_back(lv);
    run_len = en ? run_len + 1 : 0;
    if (en && (run_len % W == 0)) begin
      // A transition at sample k is counted in the window containing edge k+2.
      cnt = 0;
      lo  = (j - W - 1 < 1) ? 1 : j - W - 1;
      for (int k = lo; k <= j - 2; k++) begin
        if (lvl_q[k] == 1 && lvl_q[k-1] == 0) cnt++;
      end
      exp_q.push_back(ref_audio(cnt, inc, gsh));
    end
  endtask

  // Drive one clock of stimulus; entered and left at a falling edge.
  task automatic step(input int rfv, input bit en, input int inc, input int gsh);
    bus.rf      = D'(rfv);
    bus.ena     = en;
    bus.acc_inc = N'(inc);
    bus.gain_sh = 4'(gsh);
    model_edge(rfv, en, inc, gsh);
    @(negedge clk);
  endtask

  task automatic run_pat(input int kind, input int ncyc, input int inc, input int gsh);
    int per, hi, lo, v;
    per = $urandom_range(2, 16);
    hi  = $urandom_range(18, 31);
    lo  = $urandom_range(0, 14);
    for (int i = 0; i < ncyc; i++) begin
      case (kind)
        0:       v = (i % 4 < 2) ? 31 : 0;
        1:       v = (i % 2 == 1) ? 17 : 15;
        2:       v = (i % 4 < 2) ? 0 : 31;
        3:       v = (i % per < per / 2) ? hi : lo;
        default: v = $urandom_range(0, 31);
      endcase
      step(v, 1'b1, inc, gsh);
    end
  endtask

  // Monitor: compares each strobe against the scoreboard, audio holds otherwise.
  initial begin
    int e;
    forever begin
      @(posedge clk);
      #1;
      if (bus.audio_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("audio", int'(bus.audio), e);
          last_audio = e;
        end
      end else begin
        check("missing_strobe", exp_q.size(), 0);
        exp_q.delete();
        check("audio_hold", int'(bus.audio), last_audio);
      end
    end
  end

  // Stimulus.
  initial begin
    bit found;
    bus.ena = 1'b0;
    bus.rf = '0;
    bus.acc_inc = '0;
    bus.gain_sh = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_audio", int'(bus.audio), 0);
    check("reset_valid", int'(bus.audio_valid), 0);
    rst_n = 1'b1;

    run_pat(0, 4 * W, 65536, 0);          // nominal carrier
    run_pat(0, 2 * W, 65136, 2);          // +deviation
    run_pat(0, 2 * W, 65936, 2);          // -deviation
    run_pat(0, 2 * W, 0, 0);              // positive saturation
    run_pat(0, 2 * W, 262143, 0);         // negative saturation
    run_pat(1, 2 * W, 0, 0);              // inside hysteresis band
    run_pat(2, 2 * W, 65536 - 100, 0);    // full-swing square wave

    // Drop enable mid-window for 10 cycles.
    while ((run_len % W) != 500) step(31, 1'b1, 65136, 2);
    repeat (10) step(0, 1'b0, 65136, 2);
    run_pat(0, 2 * W + 37, 65136, 2);

    // Asynchronous reset mid-window.
    run_pat(0, 300, 65136, 2);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_audio", int'(bus.audio), 0);
    check("rst_mid_valid", int'(bus.audio_valid), 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_pat(0, 2 * W, 65936, 2);

    // Asynchronous reset during the strobe cycle.
    found = 1'b0;
    for (int i = 0; i < 2 * W && !found; i++) begin
      step((i % 4 < 2) ? 31 : 0, 1'b1, 65136, 2);
      if (bus.audio_valid) found = 1'b1;
    end
    check("strobe_seen", int'(found), 1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_strobe_valid", int'(bus.audio_valid), 0);
    check("rst_strobe_audio", int'(bus.audio), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomised square waves and noise, with acc_inc changing mid-window.
    for (int k = 0; k < 8; k++) begin
      int kind, len, inc, gsh;
      kind = ($urandom_range(0, 1) == 0) ? 3 : 4;
      len  = $urandom_range(W / 2, 2 * W);
      inc  = 65536 + int'($urandom_range(0, 4000)) - 2000;
      gsh  = $urandom_range(0, 6);
      run_pat(kind, len, inc, gsh);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 20)) step(0, 1'b0, inc, gsh);
      end
    end

    repeat (3) step(0, 1'b0, 0, 0);
    check("drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
